// File: rtl/spi_frame_packer.sv
// Packs CCU result bytes into SYNC, LEN, payload, CKSUM packets for spi_send.
// Ports: s_axis_* payload in, m_axis_* packet out, frame_overflow, frames_sent.
module spi_frame_packer #(
  parameter int          MAX_LEN = 64,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        frame_overflow,
  output logic [15:0] frames_sent
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);

  typedef enum logic [2:0] {
    COLLECT, DROP, HDR_SYNC, HDR_LEN, PAYLOAD, CKSUM
  } state_t;

  state_t state, state_nxt;

  logic [7:0] mem [MAX_LEN];
  logic [7:0] wr_cnt;
  logic [7:0] rd_idx;
  logic [7:0] sum;
  logic [7:0] cksum;

  logic       in_hs;
  logic       out_hs;
  logic       pay_end;

  logic [7:0] data_nxt;
  logic       valid_nxt;
  logic       last_nxt;
  logic [7:0] rd_nxt;

  assign in_hs   = s_axis_tvalid && s_axis_tready;
  assign out_hs  = m_axis_tvalid && m_axis_tready;
  assign cksum   = 8'd0 - (wr_cnt + sum);
  // rd_idx points at the byte to load next, so it
  // equals LEN while the final payload byte is on the bus.
  assign pay_end = (rd_idx == wr_cnt);

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) state <= COLLECT;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: begin
        if (in_hs) begin
          if (s_axis_tlast)            state_nxt = HDR_SYNC;
          else if (wr_cnt == LAST_IDX) state_nxt = DROP;
        end
      end
      DROP: begin
        if (in_hs && s_axis_tlast) state_nxt = HDR_SYNC;
      end
      HDR_SYNC: if (out_hs) state_nxt = HDR_LEN;
      HDR_LEN:  if (out_hs) state_nxt = PAYLOAD;
      PAYLOAD:  if (out_hs && pay_end) state_nxt = CKSUM;
      CKSUM:    if (out_hs) state_nxt = COLLECT;
      default:  state_nxt = COLLECT;
    endcase
  end

  // Next value of the registered master outputs. Each
  // handshake loads the following byte, so the buffer
  // read is effectively prefetched and no bubbles occur.
  always_comb begin
    data_nxt  = m_axis_tdata;
    valid_nxt = m_axis_tvalid;
    last_nxt  = m_axis_tlast;
    rd_nxt    = rd_idx;
    unique case (state)
      COLLECT, DROP: begin
        if (state_nxt == HDR_SYNC) begin
          valid_nxt = 1'b1;
          data_nxt  = SYNC;
        end
      end
      HDR_SYNC: begin
        if (out_hs) data_nxt = wr_cnt;
      end
      HDR_LEN: begin
        if (out_hs) begin
          data_nxt = mem[0];
          rd_nxt   = 8'd1;
        end
      end
      PAYLOAD: begin
        if (out_hs) begin
          if (pay_end) begin
            data_nxt = cksum;
            last_nxt = 1'b1;
          end else begin
            data_nxt = mem[rd_idx[AW-1:0]];
            rd_nxt   = rd_idx + 8'd1;
          end
        end
      end
      CKSUM: begin
        if (out_hs) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          data_nxt  = 8'h00;
          rd_nxt    = 8'd0;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      m_axis_tdata   <= 8'h00;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      s_axis_tready  <= 1'b0;
      frame_overflow <= 1'b0;
      frames_sent    <= 16'h0000;
      wr_cnt         <= 8'd0;
      rd_idx         <= 8'd0;
      sum            <= 8'd0;
    end else begin
      m_axis_tdata   <= data_nxt;
      m_axis_tvalid  <= valid_nxt;
      m_axis_tlast   <= last_nxt;
      rd_idx         <= rd_nxt;
      s_axis_tready  <= (state_nxt == COLLECT) ||
                        (state_nxt == DROP);
      frame_overflow <= (state == DROP) && in_hs &&
                        s_axis_tlast;
      if (state == COLLECT && in_hs) begin
        wr_cnt <= wr_cnt + 8'd1;
        sum    <= sum + s_axis_tdata;
      end
      if (state == CKSUM && out_hs) begin
        frames_sent <= frames_sent + 16'd1;
        wr_cnt      <= 8'd0;
        sum         <= 8'd0;
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (state == COLLECT && in_hs)
      mem[wr_cnt[AW-1:0]] <= s_axis_tdata;
  end

endmodule

// File: doc/spi_frame_packer.md
# spi_frame_packer

Frames raw CCU result bytes into self-describing packets for the SPI read-back path. It sits directly upstream of `spi_send`: its master AXI4-Stream port drives `spi_send`'s `axis_rdata/axis_rvalid/axis_rready/axis_rlast`. It buffers a whole payload so it can prepend a sync byte and a length byte, then appends a checksum byte marked with tlast. Emitted packet: SYNC, LEN, payload[0..LEN-1], CKSUM.

## Interface
Parameters:
- `MAX_LEN`, 64: payload buffer depth in bytes; legal range 1..255.
- `SYNC`, 8'hA5: first byte of every packet.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `axis_aclk`  in  1  sole clock; all logic on its rising edge.
- `axis_aresetn`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  8  payload byte from the CCU.
- `s_axis_tvalid`  in  1  payload byte valid.
- `s_axis_tready`  out  1  block accepts a payload byte.
- `s_axis_tlast`  in  1  last payload byte of a frame.
- `m_axis_tdata`  out  8  packet byte to `spi_send`.
- `m_axis_tvalid`  out  1  packet byte valid.
- `m_axis_tready`  in  1  `spi_send` accepts the byte.
- `m_axis_tlast`  out  1  high on the CKSUM byte only.
- `frame_overflow`  out  1  one-cycle pulse when an oversize frame is truncated.
- `frames_sent`  out  16  count of completed packets; wraps 0xFFFF→0x0000.

## Operation
- States:
  - COLLECT: `s_axis_tready`=1. Each accepted byte is written to `buf[wr_cnt]`, then `wr_cnt`++ and `sum` += byte.
    - Accepted byte has tlast=1 → HDR_SYNC.
    - Byte number MAX_LEN is accepted with tlast=0 → DROP.
  - DROP: `s_axis_tready`=1. Bytes are consumed and discarded.
    - Accepted byte has tlast=1 → HDR_SYNC, and `frame_overflow` pulses for 1 cycle.
  - HDR_SYNC: drives `SYNC`.
  - HDR_LEN: drives LEN = `wr_cnt`.
  - PAYLOAD: drives `buf[rd_idx]` for `rd_idx` = 0..LEN-1.
  - CKSUM: drives CKSUM with tlast=1. On handshake, `frames_sent`++, clear `wr_cnt`, `rd_idx` and `sum`, and go to COLLECT.
- Ready rule: `s_axis_tready`=0 in HDR_SYNC, HDR_LEN, PAYLOAD and CKSUM. Input is fully stalled during emission.
- Checksum: CKSUM = (0 − (LEN + Σpayload)) mod 256. Therefore LEN + payload + CKSUM ≡ 0 mod 256. `sum` is 8-bit and wraps.
- Length byte: LEN ≥ 1 always, because tlast rides on a data byte. LEN ≤ MAX_LEN. After truncation LEN = MAX_LEN, and the checksum covers only the stored bytes.
- Exact fit: a frame of exactly MAX_LEN bytes whose last byte carries tlast is not an overflow, and no pulse is generated.
- Emission states advance only on `m_axis_tvalid && m_axis_tready`.

## Timing
- Reset values (while `axis_aresetn`=0, applied asynchronously):
  - state = COLLECT; `s_axis_tready`=0 (registered; rises on the first clock edge after release).
  - `m_axis_tvalid`=0, `m_axis_tdata`=8'h00, `m_axis_tlast`=0.
  - `frame_overflow`=0, `frames_sent`=0; internal counters and `sum` cleared.
- Outputs `m_axis_*` are registered.
- AXI rules on the master port:
  - Once `m_axis_tvalid` is asserted, it, `m_axis_tdata` and `m_axis_tlast` stay stable until the handshake.
  - Valid never depends combinationally on `m_axis_tready`.
- Latency: the cycle after the input tlast handshake, `m_axis_tvalid`=1 with `SYNC`.
- Throughput: with `m_axis_tready` held high, one packet byte per cycle with no bubbles (LEN+3 cycles per packet). The buffer read must be prefetched to achieve this.
- Return to input: the cycle after the CKSUM handshake, `s_axis_tready`=1.
- `frame_overflow` is registered; it is high in the cycle following the tlast handshake in DROP.
- Reset mid-emission: the packet is abandoned at once. Output valid drops immediately and no partial tail is resumed after reset.
- `buf` contents need no reset.

## Test plan
- Input 01,02,03 (tlast on 03), `m_axis_tready`=1 → A5,03,01,02,03,F7; tlast only on F7; `frames_sent`=1; valid first asserted 1 cycle after input tlast.
- Single byte 00 with tlast → A5,01,00,FF; `s_axis_tready` back to 1 the cycle after the FF handshake.
- Overflow with MAX_LEN=4, input 10..15 (tlast on 15) → A5,04,10,11,12,13,B6; `frame_overflow` pulses exactly once; exact-fit 4-byte frame gives no pulse.
- Random `m_axis_tready` backpressure on the 3-byte frame → identical byte sequence; tdata/tlast stable while valid && !ready; `s_axis_tready`=0 throughout emission.
- Assert `axis_aresetn` low during PAYLOAD → `m_axis_tvalid` goes 0 without a clock edge. After release, a new frame 05 gives A5,01,05,FA with `frames_sent`=1.
- Preload `frames_sent` to 0xFFFF via 65535 frames (or a forced bench shortcut), send one more → `frames_sent` = 0x0000.
